// File: rtl/pixel_expander.sv
// pixel_expander
//   Converts a stream of 8-bit unsigned pixels into S.7 fixed-point samples.
//   Each line gets PAD copies of its first pixel added at the start and PAD
//   copies of its last pixel added at the end. This prepares the line for an
//   interpolation filter that needs neighbours past the line edges.
//
//   Parameters
//     LINE_W  input pixels per line (1..4095)
//     PAD     edge-replicated samples added at each end (0..3)
//
//   Ports
//     clk      single clock, rising edge
//     rst_n    asynchronous active-low reset
//     s_valid  upstream pixel valid
//     s_ready  block accepts s_pixel this cycle
//     s_pixel  unsigned 8-bit pixel
//     m_valid  output sample valid
//     m_ready  downstream accepts m_data this cycle
//     m_data   20-bit two's-complement S.7 sample (pixel x 128)
//     m_sol    first sample of a line (qualified by m_valid)
//     m_eol    last sample of a line (qualified by m_valid)
module pixel_expander #(
  parameter int LINE_W = 64,
  parameter int PAD    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_pixel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [19:0] m_data,
  output logic        m_sol,
  output logic        m_eol
);

  localparam int CW = $clog2(LINE_W + 1);
  localparam int PW = (PAD < 1) ? 1 : $clog2(PAD + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);
  localparam logic [PW-1:0] LAST_PAD = PW'((PAD > 0) ? PAD - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRE_PAD, BODY, POST_PAD} state_t;

  // Pixel to S.7: the pixel becomes the integer part and the 7 fraction
  // bits are zero. The sign bit is always zero.
  function automatic logic signed [19:0] to_fixed(input logic [7:0] pix);
    return signed'({4'b0000, pix, 7'b0000000});
  endfunction

  state_t               state, state_n;
  logic [CW-1:0]        col_cnt, col_n;
  logic [PW-1:0]        pad_cnt, pad_n;
  logic [7:0]           edge_reg, edge_n;
  logic                 adv;
  logic                 load;
  logic signed [19:0]   ld_data;
  logic                 ld_sol, ld_eol;

  logic                 vld_p1;
  logic signed [19:0]   data_p1;
  logic                 sol_p1, eol_p1;

  // The output register can take a new sample when it is empty or its
  // current sample transfers on this edge.
  assign adv     = !vld_p1 || m_ready;
  assign s_ready = rst_n && ((state == IDLE) || (state == BODY)) && adv;

  always_comb begin
    state_n = state;
    col_n   = col_cnt;
    pad_n   = pad_cnt;
    edge_n  = edge_reg;
    load    = 1'b0;
    ld_data = to_fixed(edge_reg);
    ld_sol  = 1'b0;
    ld_eol  = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid && adv) begin
          load    = 1'b1;
          ld_data = to_fixed(s_pixel);
          ld_sol  = 1'b1;
          edge_n  = s_pixel;
          col_n   = CW'(1);
          pad_n   = '0;
          if (PAD > 0) begin
            state_n = PRE_PAD;
          end else if (LINE_W > 1) begin
            state_n = BODY;
          end else begin
            ld_eol  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      PRE_PAD: begin
        if (adv) begin
          load  = 1'b1;
          pad_n = pad_cnt + PW'(1);
          if (pad_cnt == LAST_PAD) begin
            pad_n   = '0;
            // A one-pixel line has no body; go straight to the trailing pad.
            state_n = (LINE_W == 1) ? POST_PAD : BODY;
          end
        end
      end
      BODY: begin
        if (s_valid && adv) begin
          load    = 1'b1;
          ld_data = to_fixed(s_pixel);
          col_n   = col_cnt + CW'(1);
          if (col_cnt == LAST_COL) begin
            edge_n = s_pixel;
            pad_n  = '0;
            if (PAD > 0) begin
              state_n = POST_PAD;
            end else begin
              ld_eol  = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      POST_PAD: begin
        if (adv) begin
          load  = 1'b1;
          pad_n = pad_cnt + PW'(1);
          if (pad_cnt == LAST_PAD) begin
            ld_eol  = 1'b1;
            pad_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      col_cnt  <= '0;
      pad_cnt  <= '0;
      edge_reg <= '0;
    end else begin
      state    <= state_n;
      col_cnt  <= col_n;
      pad_cnt  <= pad_n;
      edge_reg <= edge_n;
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sol_p1  <= 1'b0;
      eol_p1  <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= ld_data;
      sol_p1  <= ld_sol;
      eol_p1  <= ld_eol;
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = data_p1;
  assign m_sol   = sol_p1;
  assign m_eol   = eol_p1;

endmodule
